// File: rtl/seq_arith_unit.sv
// Purpose: 8-bit sequential add/sub/mul/div unit with start/done handshake (shift-add mul, restoring div).
// Latency: add/sub done 1 cycle after start; mul/div done 9 cycles after start (8 CALC iterations).
// Backpressure: none; i_start is sampled only in IDLE, busy starts are dropped. Option macro: SEQ_ARITH_REM_EN exposes o_remainder.
module seq_arith_unit (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [1:0] i_op,
    input  logic [7:0] i_value_a,
    input  logic [7:0] i_value_b,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_result,
    output logic       o_div_zero
`ifdef SEQ_ARITH_REM_EN
    ,
    output logic [7:0] o_remainder
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [2:0] cnt;        // iteration index 0..7 while in CALC
    logic       op_div;     // latched op bit 0: 1 = div, 0 = mul (only meaningful in CALC)
    logic [7:0] a_q;        // latched multiplicand / dividend
    logic [7:0] b_q;        // latched multiplier / divisor
    logic [7:0] acc;        // product accumulator (mul) or quotient shift register (div)
    logic [7:0] rem_q;      // partial remainder, kept even when the port is not built

    logic [7:0] mul_addend;
    logic [7:0] mul_next;
    logic [8:0] div_trial;
    logic [8:0] div_diff;
    logic       div_ge;
    logic [7:0] rem_next;
    logic [7:0] quo_next;
    logic [7:0] acc_next;
    logic       b_zero;
    logic [7:0] result_final;
    logic [7:0] rem_final;

    // One iteration of shift-add multiply (LSB first) and restoring divide (MSB first)
    always_comb begin
        mul_addend   = 8'h00;
        if (b_q[cnt]) begin
            mul_addend = a_q << cnt;
        end
        mul_next     = acc + mul_addend;

        div_trial    = {rem_q, a_q[3'd7 - cnt]};
        div_ge       = (div_trial >= {1'b0, b_q});
        div_diff     = div_trial - {1'b0, b_q};
        rem_next     = div_ge ? div_diff[7:0] : div_trial[7:0];
        quo_next     = {acc[6:0], div_ge};

        acc_next     = op_div ? quo_next : mul_next;
        b_zero       = (b_q == 8'h00);
        // A zero divisor still runs all iterations; the reported values are forced here
        result_final = (op_div && b_zero) ? 8'hFF : acc_next;
        rem_final    = b_zero ? a_q : rem_next;
    end

    // Next-state logic and state-derived handshake outputs
    always_comb begin
        state_next = state;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = i_op[1] ? CALC : DONE;
                end
            end
            CALC: begin
                o_busy = 1'b1;
                if (cnt == 3'd7) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_busy     = 1'b1;
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latch, iteration datapath and result registers (updated only on entry to DONE)
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt        <= 3'd0;
            op_div     <= 1'b0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            acc        <= 8'h00;
            rem_q      <= 8'h00;
            o_result   <= 8'h00;
            o_div_zero <= 1'b0;
`ifdef SEQ_ARITH_REM_EN
            o_remainder <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        op_div <= i_op[0];
                        a_q    <= i_value_a;
                        b_q    <= i_value_b;
                        cnt    <= 3'd0;
                        acc    <= 8'h00;
                        rem_q  <= 8'h00;
                        if (!i_op[1]) begin
                            o_result   <= i_op[0] ? (i_value_a - i_value_b)
                                                  : (i_value_a + i_value_b);
                            o_div_zero <= 1'b0;
`ifdef SEQ_ARITH_REM_EN
                            o_remainder <= 8'h00;
`endif
                        end
                    end
                end
                CALC: begin
                    cnt   <= cnt + 3'd1;
                    acc   <= acc_next;
                    rem_q <= rem_next;
                    if (cnt == 3'd7) begin
                        o_result   <= result_final;
                        o_div_zero <= op_div && b_zero;
`ifdef SEQ_ARITH_REM_EN
                        o_remainder <= op_div ? rem_final : 8'h00;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/seq_arith_unit.md
# seq_arith_unit

Multi-cycle 8-bit arithmetic unit with a start/done handshake. It computes add, subtract, multiply and divide on two latched operands. Add and subtract finish in one cycle. Multiply uses an iterative shift-add and divide uses restoring division, so neither needs a combinational multiplier or divider. The unit sits beside the combinational arithmetic datapath and serves timing-critical paths, where the caller issues an operation and waits for the done pulse.

## Interface
Parameters:
- none (width fixed at 8 bits)

Ports:
- i_clk  input  1  clock; all state changes on the rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_start  input  1  request; sampled only in IDLE
- i_op  input  2  operation select: 00 add, 01 sub, 10 mul, 11 div
- i_value_a  input  8  operand A (dividend for div)
- i_value_b  input  8  operand B (divisor for div)
- o_busy  output  1  high in CALC and DONE states
- o_done  output  1  single-cycle completion pulse
- o_result  output  8  result; held until the next completion
- o_div_zero  output  1  high with o_done when the div had B = 0; held with o_result
- o_remainder  output  8  division remainder (present only with SEQ_ARITH_REM_EN)

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE & i_start:
  - latch i_op, i_value_a, i_value_b
  - add/sub: compute into the result register, go to DONE
  - mul/div: clear the accumulator, load iteration counter = 0, go to CALC
- IDLE & !i_start: stay.
- CALC: one iteration per cycle, counter 0..7. After iteration 7, go to DONE.
  - mul: shift-add over B bits LSB first; keep the low 8 bits of the product (mod 256)
  - div: restoring division, MSB first; quotient and remainder are 8 bits each
- DONE: o_done = 1 for exactly one cycle; o_result/o_div_zero/o_remainder update on entry to DONE; next state IDLE.
- Arithmetic rules:
  - add and sub wrap mod 256 (200+100 = 44, 5−10 = 251)
  - mul returns product[7:0]
- Divide by zero: still takes the full 8 CALC cycles.
  - o_result = 8'hFF, o_div_zero = 1
  - remainder = A
- o_div_zero = 0 for every other completion.
- i_start outside IDLE is ignored: no queuing, no operand update.
- Operand inputs may change freely after the start cycle.

## Timing
- Start cycle = cycle 0 (i_start high in IDLE at edge 0).
- Latency of o_done:
  - add/sub: high in cycle 1
  - mul/div: high in cycle 9
- o_busy:
  - add/sub: high in cycle 1
  - mul/div: high in cycles 1..9
- Back in IDLE at cycle 2 (add/sub) or cycle 10 (mul/div). The earliest next accepted start is in that cycle.
- Throughput:
  - add/sub: one op per 2 cycles
  - mul/div: one op per 10 cycles
- Reset (i_rst_n low at an edge) takes priority over everything:
  - state ← IDLE
  - o_busy, o_done, o_div_zero ← 0
  - o_result, o_remainder ← 8'h00
  - the counter is cleared
- Reset mid-CALC aborts the op: no o_done is produced and the result is not updated.
- i_start coincident with reset is dropped.

## Configuration
- SEQ_ARITH_REM_EN defined:
  - the o_remainder port exists
  - it updates on entry to DONE for div ops (= A when B = 0)
  - after add/sub/mul completions it is 8'h00
- SEQ_ARITH_REM_EN undefined:
  - the port and its register are absent
  - the divider still computes the remainder internally
  - all other behaviour is identical

## Test plan
- Add, A=200 B=100 op=00, start at cycle 0 → o_done in cycle 1 only, o_result=44, o_busy high in cycle 1 only.
- Sub, A=5 B=10 → o_result=251 at cycle 1. Then mul A=20 B=20, started in cycle 2 → o_done in cycle 11, o_result=144, o_busy high cycles 3..11.
- Div, A=200 B=7 → o_done in cycle 9, o_result=28, o_div_zero=0, o_remainder=4 (REM_EN build).
- Div, A=9 B=0 → o_done in cycle 9, o_result=8'hFF, o_div_zero=1, o_remainder=9 (REM_EN build).
- Mul, A=13 B=11 started; i_start pulsed again at cycle 4 with A=1 B=1 → single o_done in cycle 9 with o_result=143; no second completion.
- Div, A=100 B=3 started; i_rst_n low at cycle 5 → o_busy, o_done, o_result all 0 from cycle 6; no o_done ever. A new start after reset release completes normally.
